// File: rtl/win_checker.sv
// win_checker: scans a 7x6 board snapshot for four-in-a-row, one anchor
// cell per cycle. It reports the winner, a draw, and the anchor and direction
// of the winning line.
// Cell (c,r) is stored at bits [2*(6*c+r)+1 : 2*(6*c+r)]. Row 0 is the bottom row.
// Cell codes: 00 empty, 01 player 1, 10 player 2. Code 11 is treated as empty.
module win_checker (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [83:0] board,
   output logic        busy,
   output logic        done,
   output logic [1:0]  winner,
   output logic        draw,
   output logic [2:0]  win_col,
   output logic [2:0]  win_row,
   output logic [1:0]  win_dir
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [1:0] DIR_H  = 2'b00;
   localparam logic [1:0] DIR_V  = 2'b01;
   localparam logic [1:0] DIR_DU = 2'b10;
   localparam logic [1:0] DIR_DD = 2'b11;

   localparam logic [2:0] LAST_COL = 3'd6;
   localparam logic [2:0] LAST_ROW = 3'd5;

   // Fetch one cell from the snapshot. Coordinates off the board read as
   // empty, so an out-of-range probe can never look like a player cell.
   function automatic logic [1:0] cell_at(input logic [83:0] b,
                                          input int c,
                                          input int r);
      logic [6:0] idx;
      if ((c >= 0) && (c <= 6) && (r >= 0) && (r <= 5)) begin
         idx = 7'(2 * (6 * c + r));
         cell_at = b[idx +: 2];
      end else begin
         cell_at = 2'b00;
      end
   endfunction

   // True when the code belongs to a player. 00 and 11 do not.
   function automatic logic is_player(input logic [1:0] v);
      is_player = (v == 2'b01) || (v == 2'b10);
   endfunction

   // Four cells form a line when they all hold the same player code.
   function automatic logic line_ok(input logic [1:0] a,
                                    input logic [1:0] b,
                                    input logic [1:0] c,
                                    input logic [1:0] d);
      line_ok = is_player(a) && (a == b) && (a == c) && (a == d);
   endfunction

   // A board is full only when every one of the 42 cells holds a player code.
   function automatic logic board_full(input logic [83:0] b);
      logic full;
      full = 1'b1;
      for (int i = 0; i < 42; i++) begin
         if (!is_player(b[2*i +: 2])) begin
            full = 1'b0;
         end else begin
            full = full;
         end
      end
      board_full = full;
   endfunction

   state_t      state_q, state_d;
   logic [83:0] snap_q, snap_d;
   logic [2:0]  col_q, col_d;
   logic [2:0]  row_q, row_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  winner_q, winner_d;
   logic        draw_q, draw_d;
   logic [2:0]  win_col_q, win_col_d;
   logic [2:0]  win_row_q, win_row_d;
   logic [1:0]  win_dir_q, win_dir_d;

   // Per-anchor evaluation results.
   logic        h_match_s, v_match_s, du_match_s, dd_match_s;
   logic        any_match_s;
   logic [1:0]  match_dir_s;
   logic [1:0]  match_code_s;
   logic [1:0]  anchor_cell_s;
   logic        last_anchor_s;
   logic        full_s;

   // Evaluate the current anchor in all four directions against the snapshot.
   // Each direction is gated by its own bounds check.
   always_comb begin
      int c;
      int r;
      c = int'(col_q);
      r = int'(row_q);
      anchor_cell_s = cell_at(snap_q, c, r);

      if (col_q <= 3'd3) begin
         h_match_s = line_ok(cell_at(snap_q, c,     r),
                             cell_at(snap_q, c + 1, r),
                             cell_at(snap_q, c + 2, r),
                             cell_at(snap_q, c + 3, r));
      end else begin
         h_match_s = 1'b0;
      end

      if (row_q <= 3'd2) begin
         v_match_s = line_ok(cell_at(snap_q, c, r),
                             cell_at(snap_q, c, r + 1),
                             cell_at(snap_q, c, r + 2),
                             cell_at(snap_q, c, r + 3));
      end else begin
         v_match_s = 1'b0;
      end

      if ((col_q <= 3'd3) && (row_q <= 3'd2)) begin
         du_match_s = line_ok(cell_at(snap_q, c,     r),
                              cell_at(snap_q, c + 1, r + 1),
                              cell_at(snap_q, c + 2, r + 2),
                              cell_at(snap_q, c + 3, r + 3));
      end else begin
         du_match_s = 1'b0;
      end

      if ((col_q <= 3'd3) && (row_q >= 3'd3)) begin
         dd_match_s = line_ok(cell_at(snap_q, c,     r),
                              cell_at(snap_q, c + 1, r - 1),
                              cell_at(snap_q, c + 2, r - 2),
                              cell_at(snap_q, c + 3, r - 3));
      end else begin
         dd_match_s = 1'b0;
      end
   end

   // Pick the highest-priority matching direction: H > V > diagonal up > diagonal down.
   // The winning code is the anchor cell, because every cell of the line shares it.
   always_comb begin
      any_match_s  = h_match_s | v_match_s | du_match_s | dd_match_s;
      match_code_s = anchor_cell_s;
      if (h_match_s) begin
         match_dir_s = DIR_H;
      end else if (v_match_s) begin
         match_dir_s = DIR_V;
      end else if (du_match_s) begin
         match_dir_s = DIR_DU;
      end else if (dd_match_s) begin
         match_dir_s = DIR_DD;
      end else begin
         match_dir_s = DIR_H;
      end
   end

   // Detect the final anchor (6,5) and whether the snapshot is completely filled.
   always_comb begin
      last_anchor_s = (col_q == LAST_COL) && (row_q == LAST_ROW);
      full_s        = board_full(snap_q);
   end

   // Next-state and next-output logic for the IDLE/SCAN controller.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      col_d     = col_q;
      row_d     = row_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      winner_d  = winner_q;
      draw_d    = draw_q;
      win_col_d = win_col_q;
      win_row_d = win_row_q;
      win_dir_d = win_dir_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               snap_d    = board;
               col_d     = 3'd0;
               row_d     = 3'd0;
               winner_d  = 2'b00;
               draw_d    = 1'b0;
               win_col_d = 3'd0;
               win_row_d = 3'd0;
               win_dir_d = 2'b00;
               busy_d    = 1'b1;
               state_d   = SCAN;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            if (any_match_s) begin
               winner_d  = match_code_s;
               win_col_d = col_q;
               win_row_d = row_q;
               win_dir_d = match_dir_s;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else if (last_anchor_s) begin
               draw_d  = full_s;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (row_q == LAST_ROW) begin
               row_d = 3'd0;
               col_d = col_q + 3'd1;
            end else begin
               row_d = row_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and result registers. Reset aborts a scan and empties the snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         snap_q    <= 84'd0;
         col_q     <= 3'd0;
         row_q     <= 3'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         winner_q  <= 2'b00;
         draw_q    <= 1'b0;
         win_col_q <= 3'd0;
         win_row_q <= 3'd0;
         win_dir_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         col_q     <= col_d;
         row_q     <= row_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         winner_q  <= winner_d;
         draw_q    <= draw_d;
         win_col_q <= win_col_d;
         win_row_q <= win_row_d;
         win_dir_q <= win_dir_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign winner  = winner_q;
   assign draw    = draw_q;
   assign win_col = win_col_q;
   assign win_row = win_row_q;
   assign win_dir = win_dir_q;

endmodule

// File: tb/tb_win_checker.sv
// Testbench for win_checker. Expected results go into a queue when a scan
// is started. A monitor on the falling clock edge pops one entry per done pulse
// and compares it, including the latency from the accepting edge.
module tb_win_checker;

   logic        clk;
   logic        rst;
   logic        start;
   logic [83:0] board;
   logic        busy;
   logic        done;
   logic [1:0]  winner;
   logic        draw;
   logic [2:0]  win_col;
   logic [2:0]  win_row;
   logic [1:0]  win_dir;

   typedef struct {
      logic [1:0] w;
      logic       d;
      logic [2:0] c;
      logic [2:0] r;
      logic [1:0] dir;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_err;
   int   cyc;
   int   start_edge;

   win_checker dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .board   (board),
      .busy    (busy),
      .done    (done),
      .winner  (winner),
      .draw    (draw),
      .win_col (win_col),
      .win_row (win_row),
      .win_dir (win_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so the monitor can measure the latency of each scan.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] w, input logic d, input logic [2:0] c,
                               input logic [2:0] r, input logic [1:0] dir, input int lat);
      exp_t e;
      e.w = w; e.d = d; e.c = c; e.r = r; e.dir = dir; e.lat = lat;
      return e;
   endfunction

   function automatic logic [83:0] put(input logic [83:0] b, input int c, input int r,
                                       input logic [1:0] v);
      logic [83:0] t;
      t = b;
      t[2*(6*c+r) +: 2] = v;
      return t;
   endfunction

   // Compare each done pulse against the oldest expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("winner",  winner, e.w);
            check_eq("draw",    draw, e.d);
            check_eq("win_col", win_col, e.c);
            check_eq("win_row", win_row, e.r);
            check_eq("win_dir", win_dir, e.dir);
            check_eq("latency", cyc - start_edge, e.lat);
            check_eq("busy_at_done", busy, 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_scan(input logic [83:0] b, input exp_t e);
      board = b;
      start = 1'b1;
      exp_q.push_back(e);
      tick();
      start = 1'b0;
      start_edge = cyc;
      check_eq("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         check_eq("timeout", 32'd1, 32'd0);
         exp_q.delete();
      end
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},   busy, 1'b0);
      check_eq({tag, "_done"},   done, 1'b0);
      check_eq({tag, "_winner"}, winner, 2'b00);
      check_eq({tag, "_draw"},   draw, 1'b0);
      check_eq({tag, "_col"},    win_col, 3'd0);
      check_eq({tag, "_row"},    win_row, 3'd0);
      check_eq({tag, "_dir"},    win_dir, 2'b00);
   endtask

   initial begin
      logic [83:0] b;
      logic [83:0] full_b;
      logic [83:0] b30;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      start_edge = 0;
      rst = 1'b1;
      start = 1'b0;
      board = 84'd0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // P1 horizontal on the bottom row, anchor 0.
      b = 84'd0;
      for (int c = 0; c < 4; c++) b = put(b, c, 0, 2'b01);
      start_scan(b, mk(2'b01, 1'b0, 3'd0, 3'd0, 2'b00, 1));
      wait_done();

      // P2 vertical at the top of column 6, anchor 38.
      b = 84'd0;
      for (int r = 2; r < 6; r++) b = put(b, 6, r, 2'b10);
      start_scan(b, mk(2'b10, 1'b0, 3'd6, 3'd2, 2'b01, 39));
      wait_done();

      // P1 diagonal down anchored at (2,5), anchor 17.
      b = 84'd0;
      for (int i = 0; i < 4; i++) b = put(b, 2 + i, 5 - i, 2'b01);
      start_scan(b, mk(2'b01, 1'b0, 3'd2, 3'd5, 2'b11, 18));
      wait_done();

      // P2 diagonal up from (0,0).
      b = 84'd0;
      for (int i = 0; i < 4; i++) b = put(b, i, i, 2'b10);
      start_scan(b, mk(2'b10, 1'b0, 3'd0, 3'd0, 2'b10, 1));
      wait_done();

      // Full board with no lines, which is a draw.
      full_b = 84'd0;
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++)
            full_b = put(full_b, c, r, ((((r >> 1) + c) % 2) == 0) ? 2'b01 : 2'b10);
      start_scan(full_b, mk(2'b00, 1'b1, 3'd0, 3'd0, 2'b00, 42));
      wait_done();

      // The same board with one hole, so it is not a draw.
      start_scan(put(full_b, 3, 5, 2'b00), mk(2'b00, 1'b0, 3'd0, 3'd0, 2'b00, 42));
      wait_done();

      // Code 11 never forms a line.
      b = 84'd0;
      for (int c = 0; c < 4; c++) b = put(b, c, 0, 2'b11);
      start_scan(b, mk(2'b00, 1'b0, 3'd0, 3'd0, 2'b00, 42));
      wait_done();

      // P1 vertical at (5,0..3), anchor 30. A restart and a board clear at E5 must be ignored.
      b30 = 84'd0;
      for (int r = 0; r < 4; r++) b30 = put(b30, 5, r, 2'b01);
      start_scan(b30, mk(2'b01, 1'b0, 3'd5, 3'd0, 2'b01, 31));
      repeat (4) tick();
      board = 84'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      repeat (45) tick();
      check_eq("hold_winner", winner, 2'b01);
      check_eq("hold_col", win_col, 3'd5);
      check_eq("hold_dir", win_dir, 2'b01);

      // Reset at E10 aborts the scan with no done pulse.
      start_scan(b30, mk(2'b01, 1'b0, 3'd5, 3'd0, 2'b01, 31));
      repeat (9) tick();
      rst = 1'b1;
      exp_q.delete();
      #2;
      check_reset_outputs("midrst");
      tick();
      rst = 1'b0;
      repeat (50) tick();
      check_reset_outputs("postrst");

      // A normal scan after the reset.
      start_scan(b30, mk(2'b01, 1'b0, 3'd5, 3'd0, 2'b01, 31));
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/win_checker.md
# win_checker

Downstream consumer of the column-loader board: after every token drop, the game FSM pulses `start` and this block scans the 7×6 board snapshot for four-in-a-row belonging to either player. It reports winner, draw, and the anchor cell and direction of the winning line for the VGA highlight logic. The scan walks one anchor cell per cycle, so no 42-way combinational check is built.

## Interface

Parameters:
- None. The board is fixed at 7 columns × 6 rows × 2-bit cells.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle request to scan the current board
- `board`  in  84  flattened board; cell (c,r) occupies bits [2*(6*c+r)+1 : 2*(6*c+r)]; c = 0..6, r = 0..5, r = 0 is the bottom row
- `busy`  out  1  high while the scan is in progress
- `done`  out  1  one-cycle pulse when a scan concludes
- `winner`  out  2  00 none, 01 player 1, 10 player 2
- `draw`  out  1  board full and no winner
- `win_col`  out  3  anchor column of the winning line
- `win_row`  out  3  anchor row of the winning line
- `win_dir`  out  2  00 horizontal (+c), 01 vertical (+r), 10 diagonal (+c,+r), 11 diagonal (+c,−r)

## Operation

- Cell codes:
  - 00 empty, 01 P1, 10 P2.
  - 11 is treated as empty and never forms or completes a line.
- FSM states: IDLE, SCAN.
- **IDLE**
  - On `start`: capture `board` into an internal 84-bit snapshot, clear the anchor counters (col = 0, row = 0), and clear `winner`, `draw`, `win_col`, `win_row` and `win_dir`.
  - Then go to SCAN; `busy` = 1.
- **SCAN**
  - Each cycle, evaluate anchor (col,row) against the snapshot in all four directions.
  - A direction is valid only if all four cells lie in bounds:
    - horizontal: col ≤ 3
    - vertical: row ≤ 2
    - diagonal up: col ≤ 3, row ≤ 2
    - diagonal down: col ≤ 3, row ≥ 3
  - A line matches when all four cells are equal and non-empty.
  - Direction priority within an anchor: 00 > 01 > 10 > 11.
  - Scan order: row increments fastest (0..5), then col (0..6). Anchor index k = 6*col + row.
  - **Match:** register `winner` = cell code, `win_col`/`win_row` = anchor, `win_dir` = direction. Pulse `done`, drop `busy`, return to IDLE (early exit).
  - **No match at the last anchor (6,5):** set `draw` = 1 iff all 42 snapshot cells are 01 or 10. Pulse `done`, return to IDLE.
- Result outputs hold until the next accepted `start` or reset.
- `start` while in SCAN is ignored. Changes to `board` during SCAN do not affect the result.
- If both players have lines (illegal game state), the first match in scan order wins.

## Timing

- Reset values: state IDLE; `busy` 0, `done` 0, `winner` 00, `draw` 0, `win_col` 0, `win_row` 0, `win_dir` 00.
- Reset mid-scan aborts immediately. No `done` is produced, and the snapshot is cleared to all-empty.
- `start` sampled at edge E0:
  - `busy` = 1 and outputs are cleared after E0.
  - Anchor k is evaluated at edge E(k+1).
  - On a match at anchor k, `done` = 1 for exactly the cycle after E(k+1), with results valid in that same cycle; `busy` = 0 from that cycle.
  - With no match, `done` follows E42. Worst-case latency is 42 cycles.
- `start` in the same cycle as `done` is accepted (FSM is already in IDLE); the new scan begins at that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **P1 horizontal at bottom row:** cells (0..3,0) = 01, rest empty; `start` → `done` after E1; `winner` 01, `win_col` 0, `win_row` 0, `win_dir` 00, `draw` 0.
- **P2 vertical at top of last column:** cells (6,2..5) = 10 → anchor k = 38; `done` after E39; `winner` 10, `win_col` 6, `win_row` 2, `win_dir` 01.
- **P1 diagonal down:** cells (2,5),(3,4),(4,3),(5,2) = 01 → `done` after E18; `win_col` 2, `win_row` 5, `win_dir` 11.
  - Variant with (0,0),(1,1),(2,2),(3,3) = 10 → `done` after E1, `win_dir` 10.
- **Full board, no lines:** cell (c,r) = 01 when ((r>>1) + c) is even, else 10; this yields rows 0-1 and 2-3 paired with alternating columns, giving no four-in-a-row in any direction → `done` after E42; `winner` 00, `draw` 1. Same board with (3,5) = 00 → `draw` 0.
- **Mid-scan robustness:** a winning P1 line sits at anchor 30; drive `start` again at E5 and clear `board` at E5 → second `start` ignored, `done` once after E31 with `winner` 01. Repeat with `rst` asserted at E10 → all outputs at reset values, no `done`, next `start` scans normally.
- **Code 11 handling:** cells (0..3,0) = 11 → no win, `done` after E42, `winner` 00, `draw` 0.
